// File: rtl/dynamic_buff_pkg.sv
// Shared state type, sizing helpers and default sizes for the dynamic_buff
// multi-queue linked-list buffer.
package dynamic_buff_pkg;

    localparam int DEF_NUMFIFO = 8;
    localparam int DEF_NUMADDR = 16;
    localparam int DEF_BITDATA = 8;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } buff_state_t;

    // Index width, kept at one bit minimum so single-entry sizes still elaborate.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/dynamic_buff_freelist.sv
// Free-list manager for dynamic_buff: builds the initial chain of free entries,
// then hands out fhead on alloc and appends released entries at ftail.
module dynamic_buff_freelist
    import dynamic_buff_pkg::*;
#(
    parameter  int NUMADDR = DEF_NUMADDR,
    localparam int BITADDR = idx_width(NUMADDR),
    localparam int BITCNT  = cnt_width(NUMADDR)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_alloc,
    input  logic               i_release,
    input  logic [BITADDR-1:0] i_rel_addr,
    input  logic [BITADDR-1:0] i_fhead_link,
    output logic               o_ready,
    output logic [BITADDR-1:0] o_fhead,
    output logic [BITCNT-1:0]  o_fcnt,
    output logic               o_lw_en,
    output logic [BITADDR-1:0] o_lw_addr,
    output logic [BITADDR-1:0] o_lw_data,
    output buff_state_t        o_state
);

    buff_state_t        r_state;
    logic [BITADDR-1:0] r_init_ptr;
    logic [BITADDR-1:0] r_fhead;
    logic [BITADDR-1:0] r_ftail;
    logic [BITCNT-1:0]  r_fcnt;
    logic               r_ready;

    logic               w_alloc;
    logic               w_release;
    logic [BITCNT-1:0]  w_fcnt_left;
    logic               w_tail_valid;

    assign w_alloc      = (r_state == RUN) && i_alloc && (r_fcnt != '0);
    assign w_release    = (r_state == RUN) && i_release;
    assign w_fcnt_left  = r_fcnt - BITCNT'(w_alloc);
    // ftail only names a free entry while something stays on the list after alloc.
    assign w_tail_valid = (w_fcnt_left != '0);

    always_comb begin
        o_lw_en   = 1'b0;
        o_lw_addr = '0;
        o_lw_data = '0;
        if (r_state == INIT) begin
            o_lw_en   = 1'b1;
            o_lw_addr = r_init_ptr;
            o_lw_data = r_init_ptr + BITADDR'(1);
        end else if (w_release && w_tail_valid) begin
            o_lw_en   = 1'b1;
            o_lw_addr = r_ftail;
            o_lw_data = i_rel_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= INIT;
            r_init_ptr <= '0;
            r_fhead    <= '0;
            r_ftail    <= '0;
            r_fcnt     <= '0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_init_ptr <= r_init_ptr + BITADDR'(1);
                    if (r_init_ptr == BITADDR'(NUMADDR - 1)) begin
                        r_fhead <= '0;
                        r_ftail <= BITADDR'(NUMADDR - 1);
                        r_fcnt  <= BITCNT'(NUMADDR);
                        r_ready <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_alloc) begin
                        r_fhead <= i_fhead_link;
                    end
                    if (w_release) begin
                        r_ftail <= i_rel_addr;
                        if (!w_tail_valid) begin
                            r_fhead <= i_rel_addr;
                        end
                    end
                    r_fcnt <= w_fcnt_left + BITCNT'(w_release);
                end
                default: r_state <= INIT;
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_fhead = r_fhead;
    assign o_fcnt  = r_fcnt;
    assign o_state = r_state;

endmodule

// File: rtl/dynamic_buff.sv
// Multi-queue FIFO sharing one pool of entries through per-queue linked lists.
// Optional DYNAMIC_BUFF_ERR_EN adds sticky err[1:0] and self-check assertions.
module dynamic_buff
    import dynamic_buff_pkg::*;
#(
    parameter  int NUMFIFO = DEF_NUMFIFO,
    parameter  int NUMADDR = DEF_NUMADDR,
    parameter  int BITDATA = DEF_BITDATA,
    localparam int BITFIFO = idx_width(NUMFIFO),
    localparam int BITADDR = idx_width(NUMADDR),
    localparam int BITCNT  = cnt_width(NUMADDR)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               ready,
    input  logic               push,
    input  logic [BITFIFO-1:0] pu_prt,
    input  logic [BITDATA-1:0] pu_din,
    input  logic               pop,
    input  logic [BITFIFO-1:0] po_prt,
    output logic [BITDATA-1:0] po_dout,
    output logic [NUMFIFO-1:0] q_empty,
    output logic               pool_full,
`ifdef DYNAMIC_BUFF_ERR_EN
    output logic [1:0]         err,
`endif
    output logic [BITCNT-1:0]  free_cnt
);

    logic [BITDATA-1:0] r_data_mem [NUMADDR];
    logic [BITADDR-1:0] r_link_mem [NUMADDR];
    logic [BITADDR-1:0] r_head     [NUMFIFO];
    logic [BITADDR-1:0] r_tail     [NUMFIFO];
    logic [BITCNT-1:0]  r_cnt      [NUMFIFO];

    buff_state_t        w_state;
    logic               w_run;
    logic [BITADDR-1:0] w_fhead;
    logic [BITCNT-1:0]  w_fcnt;
    logic               w_fl_lw_en;
    logic [BITADDR-1:0] w_fl_lw_addr;
    logic [BITADDR-1:0] w_fl_lw_data;
    logic [BITCNT-1:0]  w_pu_cnt;
    logic [BITCNT-1:0]  w_po_cnt;
    logic [BITADDR-1:0] w_pop_addr;
    logic               w_push_ok;
    logic               w_pop_ok;
    logic               w_same_q;
    logic               w_hand_off;

    assign w_run      = (w_state == RUN);
    assign w_pu_cnt   = r_cnt[pu_prt];
    assign w_po_cnt   = r_cnt[po_prt];
    assign w_pop_addr = r_head[po_prt];

    // A full pool drops the push even when a pop frees an entry this cycle.
    assign w_push_ok  = push && w_run && (w_fcnt != '0);
    assign w_pop_ok   = pop && w_run && (w_po_cnt != '0);
    assign w_same_q   = w_push_ok && w_pop_ok && (pu_prt == po_prt);
    assign w_hand_off = w_same_q && (w_po_cnt == BITCNT'(1));

    dynamic_buff_freelist #(
        .NUMADDR (NUMADDR)
    ) u_freelist (
        .clk          (clk),
        .rst          (rst),
        .i_alloc      (w_push_ok),
        .i_release    (w_pop_ok),
        .i_rel_addr   (w_pop_addr),
        .i_fhead_link (r_link_mem[w_fhead]),
        .o_ready      (ready),
        .o_fhead      (w_fhead),
        .o_fcnt       (w_fcnt),
        .o_lw_en      (w_fl_lw_en),
        .o_lw_addr    (w_fl_lw_addr),
        .o_lw_data    (w_fl_lw_data),
        .o_state      (w_state)
    );

    // Two link write ports: free-list chaining and queue-tail chaining never
    // target the same entry, since ftail is free and tail[q] is allocated.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_fl_lw_en) begin
                r_link_mem[w_fl_lw_addr] <= w_fl_lw_data;
            end
            if (w_push_ok && (w_pu_cnt != '0)) begin
                r_link_mem[r_tail[pu_prt]] <= w_fhead;
            end
            if (w_push_ok) begin
                r_data_mem[w_fhead] <= pu_din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUMFIFO; i++) begin
                r_head[i] <= '0;
                r_tail[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_tail[pu_prt] <= w_fhead;
                if ((w_pu_cnt == '0) || w_hand_off) begin
                    r_head[pu_prt] <= w_fhead;
                end
                if (!w_same_q) begin
                    r_cnt[pu_prt] <= w_pu_cnt + BITCNT'(1);
                end
            end
            if (w_pop_ok) begin
                if (!w_hand_off) begin
                    r_head[po_prt] <= r_link_mem[w_pop_addr];
                end
                if (!w_same_q) begin
                    r_cnt[po_prt] <= w_po_cnt - BITCNT'(1);
                end
            end
        end
    end

    always_comb begin
        q_empty = '0;
        for (int i = 0; i < NUMFIFO; i++) begin
            q_empty[i] = (r_cnt[i] == '0);
        end
    end

    assign po_dout   = (w_po_cnt != '0) ? r_data_mem[w_pop_addr] : '0;
    assign pool_full = (w_fcnt == '0);
    assign free_cnt  = w_fcnt;

`ifdef DYNAMIC_BUFF_ERR_EN
    localparam int BITSUM = BITCNT + BITFIFO + 1;

    logic [1:0]         r_err;
    logic [BITDATA-1:0] r_ref_mem [NUMFIFO][NUMADDR];
    logic [BITADDR-1:0] r_ref_wp  [NUMFIFO];
    logic [BITADDR-1:0] r_ref_rp  [NUMFIFO];
    logic [BITSUM-1:0]  w_cnt_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= '0;
        end else begin
            if (push && w_run && (w_fcnt == '0)) begin
                r_err[0] <= 1'b1;
            end
            if (pop && w_run && (w_po_cnt == '0)) begin
                r_err[1] <= 1'b1;
            end
        end
    end

    assign err = r_err;

    // Independent flat per-queue ring used only to cross-check the linked lists.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUMFIFO; i++) begin
                r_ref_wp[i] <= '0;
                r_ref_rp[i] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_ref_mem[pu_prt][r_ref_wp[pu_prt]] <= pu_din;
                r_ref_wp[pu_prt] <= r_ref_wp[pu_prt] + BITADDR'(1);
            end
            if (w_pop_ok) begin
                r_ref_rp[po_prt] <= r_ref_rp[po_prt] + BITADDR'(1);
            end
        end
    end

    always_comb begin
        w_cnt_sum = BITSUM'(w_fcnt);
        for (int i = 0; i < NUMFIFO; i++) begin
            w_cnt_sum = w_cnt_sum + BITSUM'(r_cnt[i]);
        end
    end

    a_cnt_inv: assert property (@(posedge clk) disable iff (rst)
        w_run |-> (w_cnt_sum == BITSUM'(NUMADDR)));

    a_data_ref: assert property (@(posedge clk) disable iff (rst)
        (w_po_cnt != '0) |-> (po_dout == r_ref_mem[po_prt][r_ref_rp[po_prt]]));
`endif

endmodule

// File: tb/tb_dynamic_buff.sv
// Randomized bench for dynamic_buff against a queue-per-port reference model.
module tb_dynamic_buff;

    localparam int NUMFIFO = 8;
    localparam int NUMADDR = 16;
    localparam int BITDATA = 8;
    localparam int BITFIFO = 3;
    localparam int BITCNT  = 5;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ready;
    logic               push = 1'b0;
    logic [BITFIFO-1:0] pu_prt = '0;
    logic [BITDATA-1:0] pu_din = '0;
    logic               pop = 1'b0;
    logic [BITFIFO-1:0] po_prt = '0;
    logic [BITDATA-1:0] po_dout;
    logic [NUMFIFO-1:0] q_empty;
    logic               pool_full;
    logic [BITCNT-1:0]  free_cnt;
`ifdef DYNAMIC_BUFF_ERR_EN
    logic [1:0]         err;
    logic [1:0]         exp_err = '0;
`endif

    dynamic_buff #(
        .NUMFIFO (NUMFIFO),
        .NUMADDR (NUMADDR),
        .BITDATA (BITDATA)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .push      (push),
        .pu_prt    (pu_prt),
        .pu_din    (pu_din),
        .pop       (pop),
        .po_prt    (po_prt),
        .po_dout   (po_dout),
        .q_empty   (q_empty),
        .pool_full (pool_full),
`ifdef DYNAMIC_BUFF_ERR_EN
        .err       (err),
`endif
        .free_cnt  (free_cnt)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Scoreboard: one expected queue per logical queue
    logic [BITDATA-1:0] exp_q [NUMFIFO][$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [BITDATA-1:0] model_head(input int q);
        if (exp_q[q].size() != 0) return exp_q[q][0];
        return '0;
    endfunction

    function automatic int model_free();
        int used = 0;
        for (int q = 0; q < NUMFIFO; q++) used += exp_q[q].size();
        return NUMADDR - used;
    endfunction

    function automatic logic [NUMFIFO-1:0] model_empty();
        logic [NUMFIFO-1:0] v = '0;
        for (int q = 0; q < NUMFIFO; q++) v[q] = (exp_q[q].size() == 0);
        return v;
    endfunction

    task automatic model_clear();
        for (int q = 0; q < NUMFIFO; q++) exp_q[q].delete();
`ifdef DYNAMIC_BUFF_ERR_EN
        exp_err = '0;
`endif
    endtask

    // Driver: one cycle with optional push and pop; called just after a negedge.
    task automatic step(input logic do_push, input int pq, input logic [BITDATA-1:0] din,
                        input logic do_pop, input int oq);
        int free_before;
        push   = do_push;
        pu_prt = pq[BITFIFO-1:0];
        pu_din = din;
        pop    = do_pop;
        po_prt = oq[BITFIFO-1:0];
        #1;
        check("po_dout", po_dout, model_head(oq));
        free_before = model_free();
`ifdef DYNAMIC_BUFF_ERR_EN
        if (do_push && free_before == 0) exp_err[0] = 1'b1;
        if (do_pop && exp_q[oq].size() == 0) exp_err[1] = 1'b1;
`endif
        if (do_pop && exp_q[oq].size() != 0) exp_q[oq].delete(0);
        if (do_push && free_before != 0) exp_q[pq].push_back(din);
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        check("q_empty", q_empty, model_empty());
        check("free_cnt", free_cnt, model_free());
        check("pool_full", pool_full, model_free() == 0);
`ifdef DYNAMIC_BUFF_ERR_EN
        check("err", err, exp_err);
`endif
        @(negedge clk);
    endtask

    // Hold reset, check reset outputs, then time the initialisation phase.
    task automatic do_reset();
        rst  = 1'b1;
        push = 1'b0;
        pop  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 1'b0);
        check("rst_q_empty", q_empty, {NUMFIFO{1'b1}});
        check("rst_pool_full", pool_full, 1'b1);
        check("rst_free_cnt", free_cnt, 0);
        check("rst_po_dout", po_dout, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= NUMADDR; k++) begin
            push   = 1'($urandom_range(0, 1));
            pu_prt = BITFIFO'($urandom_range(0, NUMFIFO - 1));
            pu_din = BITDATA'($urandom_range(0, 255));
            pop    = 1'($urandom_range(0, 1));
            po_prt = BITFIFO'($urandom_range(0, NUMFIFO - 1));
            @(posedge clk);
            #1;
            check("init_ready", ready, k == NUMADDR);
        end
        push = 1'b0;
        pop  = 1'b0;
        @(negedge clk);
        check("init_free_cnt", free_cnt, NUMADDR);
        check("init_q_empty", q_empty, {NUMFIFO{1'b1}});
        check("init_pool_full", pool_full, 1'b0);
    endtask

    logic [BITDATA-1:0] a1, a2, b1, b2;

    initial begin
        do_reset();

        // Basic ordering on one queue
        step(1'b1, 3, 8'h11, 1'b0, 3);
        step(1'b1, 3, 8'h22, 1'b0, 3);
        step(1'b1, 3, 8'h33, 1'b0, 3);
        repeat (3) step(1'b0, 0, 8'h00, 1'b1, 3);

        // Whole pool in one queue, overflow drop, push+pop on a full pool
        for (int i = 0; i < NUMADDR; i++) step(1'b1, 0, BITDATA'($urandom_range(0, 255)), 1'b0, 0);
        step(1'b1, 0, 8'hEE, 1'b0, 0);
        step(1'b1, 0, 8'hDD, 1'b1, 0);
        step(1'b1, 0, 8'hCC, 1'b0, 0);
        step(1'b0, 0, 8'h00, 1'b1, 0);
        step(1'b1, 0, BITDATA'($urandom_range(0, 255)), 1'b0, 0);
        repeat (NUMADDR) step(1'b0, 0, 8'h00, 1'b1, 0);

        // Interleaved queues keep independent order
        a1 = BITDATA'($urandom_range(0, 255));
        a2 = BITDATA'($urandom_range(0, 255));
        b1 = BITDATA'($urandom_range(0, 255));
        b2 = BITDATA'($urandom_range(0, 255));
        step(1'b1, 1, a1, 1'b0, 5);
        step(1'b1, 5, b1, 1'b0, 5);
        step(1'b1, 1, a2, 1'b0, 5);
        step(1'b1, 5, b2, 1'b0, 5);
        repeat (2) step(1'b0, 0, 8'h00, 1'b1, 5);
        repeat (2) step(1'b0, 0, 8'h00, 1'b1, 1);

        // Same-queue push+pop with one entry left in the pool
        for (int i = 0; i < NUMADDR - 2; i++) step(1'b1, 6, BITDATA'($urandom_range(0, 255)), 1'b0, 6);
        step(1'b1, 2, 8'h42, 1'b0, 2);
        step(1'b1, 2, 8'h77, 1'b1, 2);
        step(1'b0, 0, 8'h00, 1'b1, 2);
        repeat (NUMADDR - 2) step(1'b0, 0, 8'h00, 1'b1, 6);

        // Random traffic; pop queue often matches push queue
        for (int i = 0; i < 600; i++) begin
            int pq;
            int oq;
            pq = $urandom_range(0, NUMFIFO - 1);
            oq = ($urandom_range(0, 1) == 1) ? pq : $urandom_range(0, NUMFIFO - 1);
            step($urandom_range(0, 99) < 55, pq, BITDATA'($urandom_range(0, 255)),
                 $urandom_range(0, 99) < 45, oq);
        end

        // Reset in the middle of traffic
        for (int i = 0; i < 5; i++) step(1'b1, 4, BITDATA'($urandom_range(0, 255)), 1'b0, 4);
        rst  = 1'b1;
        push = 1'b1;
        pu_prt = 3'd4;
        pop  = 1'b1;
        po_prt = 3'd4;
        @(posedge clk);
        #1;
        check("midrst_ready", ready, 1'b0);
        check("midrst_q_empty", q_empty, {NUMFIFO{1'b1}});
        check("midrst_free_cnt", free_cnt, 0);
        do_reset();
        step(1'b0, 0, 8'h00, 1'b1, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dynamic_buff.md
Name: dynamic_buff

Overview:
Multi-queue FIFO buffer in which NUMFIFO logical queues share one pool of NUMADDR data entries. Queues are built as linked lists, with a hardware free list, so any queue can use up to the whole pool. This is the next generation of the statically partitioned queue buffer used in circular-buffer designs. It adds dynamic allocation, per-queue occupancy, occupancy flags and an initialisation phase.

Parameters:
NUMFIFO, 8, number of logical queues
NUMADDR, 16, total shared entries; power of two, >= 2
BITDATA, 8, data width
Derived localparams: BITFIFO=$clog2(NUMFIFO), BITADDR=$clog2(NUMADDR), BITCNT=$clog2(NUMADDR+1)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
ready  out  1  free-list initialisation complete; push/pop accepted only when high
push  in  1  enqueue request
pu_prt  in  BITFIFO  target queue for push
pu_din  in  BITDATA  push data
pop  in  1  dequeue request
po_prt  in  BITFIFO  target queue for pop
po_dout  out  BITDATA  head data of queue po_prt, combinational; 0 when that queue is empty
q_empty  out  NUMFIFO  bit i high when queue i count is 0
pool_full  out  1  free count is 0
free_cnt  out  BITCNT  number of unallocated entries

Behaviour:
- State: per queue head, tail and cnt. Pool: link_mem[NUMADDR] of BITADDR, data_mem[NUMADDR] of BITDATA. Free list: fhead, ftail, fcnt.
- Reset:
  - All cnt = 0, fcnt = 0, ready = 0, init pointer = 0.
  - Outputs during reset: q_empty all 1s, pool_full = 1, free_cnt = 0, po_dout = 0.
- INIT state:
  - One entry per cycle: link_mem[i] = i+1.
  - After NUMADDR cycles: fhead = 0, ftail = NUMADDR-1, fcnt = NUMADDR, then move to RUN with ready = 1.
  - ready rises exactly NUMADDR cycles after rst is deasserted.
  - push and pop are ignored while ready = 0.
- RUN, accepted push (push && ready && fcnt != 0):
  - a = fhead; data_mem[a] = pu_din.
  - If cnt[q] == 0, head[q] = a; otherwise link_mem[tail[q]] = a.
  - tail[q] = a; cnt[q]++; fhead = link_mem[a]; fcnt--.
  - A push with fcnt == 0 is dropped, even if a pop frees an entry in the same cycle.
- RUN, accepted pop (pop && ready && cnt[q] != 0):
  - Data is taken from po_dout in the same cycle.
  - r = head[q]; head[q] = link_mem[r]; cnt[q]--.
  - r is appended to the free list: link_mem[ftail] = r, ftail = r, fcnt++.
  - A pop of an empty queue is ignored.
- Simultaneous push and pop:
  - Both take effect in one cycle. link_mem needs two write ports.
  - Same queue with cnt == 1: the popped entry leaves, the pushed entry becomes both head and tail, cnt stays 1.
  - Push takes the last free entry (fcnt == 1) while a pop returns r: fhead = ftail = r, fcnt stays 1.
- Counters:
  - Pointer arithmetic never wraps modulo; addresses come only from the free list.
  - Invariant: sum of all cnt + fcnt == NUMADDR.
- Reset mid-operation: all state is lost; the block re-enters INIT and ready drops on the next cycle.
- Latency: a pushed value is visible on po_dout (when po_prt selects that queue) in the cycle after the push.

Optional Feature:
DYNAMIC_BUFF_ERR_EN
- Defined: adds output err[1:0]. Bit 0 is sticky on a dropped push (pool full). Bit 1 is sticky on a pop of an empty queue. Both bits are cleared only by rst. Adds formal asserts for the count invariant and a per-queue reference-model data check.
- Undefined: port and logic are absent; illegal requests are silently ignored.

Decomposition:
- Package dynamic_buff_pkg holds:
  - the state enum {INIT, RUN};
  - width-computation functions;
  - the default parameter constants.
- Sub-module dynamic_buff_freelist holds init counter, fhead/ftail/fcnt and the alloc/release handshake. Queue pointers and data_mem stay in the top level.

Test Plan:
- Reset release -> ready low for exactly 16 cycles, then high; free_cnt = 16, q_empty = 8'hFF.
- Push 0x11, 0x22, 0x33 to queue 3, then pop 3 times -> po_dout 0x11, 0x22, 0x33; q_empty[3] returns to 1; free_cnt back to 16.
- Fill queue 0 with 16 pushes -> pool_full = 1. A 17th push is dropped (err[0] = 1 with the macro). One pop and one push, then drain -> order preserved.
- Interleave pushes to queues 1 and 5 (A1, B1, A2, B2), pop queue 5 twice then queue 1 twice -> B1, B2, A1, A2.
- Queue 2 holds 1 entry, free_cnt = 1; push 0x77 and pop queue 2 in the same cycle -> old head is output, free_cnt stays 1, next pop gives 0x77.
- Assert rst during traffic -> all queues empty, ready low for 16 cycles; pop of an empty queue afterwards gives po_dout = 0 and sets err[1].
